// File: rtl/fsm_ab_stim_driver.sv
// Stimulus driver for the a/b inputs of the multi-segment example FSM.
// Replays (a, b, hold-length) steps gap-free and counts busy cycles with y0/y1 high.
module fsm_ab_stim_driver #(
  parameter int LW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step_valid,
  output logic          step_ready,
  input  logic          step_a,
  input  logic          step_b,
  input  logic [LW-1:0] step_len,
  output logic          a,
  output logic          b,
  input  logic          y0,
  input  logic          y1,
  output logic          busy,
  input  logic          cnt_clr,
  output logic [CW-1:0] y0_cnt,
  output logic [CW-1:0] y1_cnt
);

  typedef enum logic {IDLE, DRIVE} state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state;
  logic [LW-1:0] rem;
  logic          take;
  logic          last_cycle;

  // A step can be taken during the final DRIVE cycle so consecutive steps abut.
  assign last_cycle = (state == DRIVE) && (rem == LW'(1));
  assign step_ready = !reset && ((state == IDLE) || last_cycle);
  assign take       = step_valid && step_ready;

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a     <= 1'b0;
      b     <= 1'b0;
      rem   <= '0;
      busy  <= 1'b0;
    end else if (take) begin
      if (step_len != '0) begin
        a     <= step_a;
        b     <= step_b;
        rem   <= step_len;
        state <= DRIVE;
        busy  <= 1'b1;
      end else begin
        rem   <= '0;
        state <= IDLE;
        busy  <= 1'b0;
      end
    end else if (state == DRIVE) begin
      rem <= rem - LW'(1);
      if (last_cycle) begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end

  // Counters sample y0/y1 only while a step is on the wire, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      y0_cnt <= '0;
      y1_cnt <= '0;
    end else if (busy) begin
      if (y0 && (y0_cnt != CNT_MAX)) y0_cnt <= y0_cnt + CW'(1);
      if (y1 && (y1_cnt != CNT_MAX)) y1_cnt <= y1_cnt + CW'(1);
    end
  end

endmodule
